// File: rtl/carry_skip_adder_pipe_if.sv
// Operand/result handshake bundle for carry_skip_adder_pipe.
// The sub signal exists only when ADD_SUB_EN is defined.
interface carry_skip_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef ADD_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder with valid/ready flow control and collapsing bubbles.
// Define ADD_SUB_EN to add the sub input (a + ~b + 1 when sub = 1).
module carry_skip_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4,
  parameter int PIPE  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  carry_skip_adder_pipe_if.slave   bus
);
  localparam int SLICE = WIDTH / PIPE;
  localparam int NBLK  = SLICE / BLOCK;

  logic             r_vld [PIPE];
  logic [WIDTH-1:0] r_a   [PIPE];
  logic [WIDTH-1:0] r_b   [PIPE];
  logic [WIDTH-1:0] r_sum [PIPE];
  logic             r_c   [PIPE];
  logic             r_ovf [PIPE];

  logic             w_adv     [PIPE];
  logic             w_vld_src [PIPE];
  logic [WIDTH-1:0] w_a_src   [PIPE];
  logic [WIDTH-1:0] w_b_src   [PIPE];
  logic [WIDTH-1:0] w_s_src   [PIPE];
  logic [WIDTH-1:0] w_s_nx    [PIPE];
  logic             w_c_src   [PIPE];
  logic [SLICE+1:0] w_res     [PIPE];
  logic [WIDTH-1:0] w_b0;
  logic             w_c0;

  // Returns {slice carry out, carry into slice MSB, slice sum}.
  function automatic logic [SLICE+1:0] slice_add(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic ci);
    logic [SLICE-1:0] s;
    logic c, cb, p, c_msb;
    int   idx;
    s     = {SLICE{1'b0}};
    c     = ci;
    c_msb = 1'b0;
    for (int blk = 0; blk < NBLK; blk++) begin
      cb = c;
      p  = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        idx    = blk * BLOCK + i;
        p      = p & (x[idx] ^ y[idx]);
        s[idx] = x[idx] ^ y[idx] ^ cb;
        if (idx == SLICE - 1) begin
          c_msb = cb;
        end else begin
          c_msb = c_msb;
        end
        cb = (x[idx] & y[idx]) | (cb & (x[idx] ^ y[idx]));
      end
      c = p ? c : cb;
    end
    return {c, c_msb, s};
  endfunction

  // Subtraction is folded into stage 0 as inverted B with forced carry-in.
  always_comb begin
`ifdef ADD_SUB_EN
    w_b0 = bus.sub ? ~bus.b : bus.b;
    w_c0 = bus.sub ? 1'b1 : bus.cin;
`else
    w_b0 = bus.b;
    w_c0 = bus.cin;
`endif
  end

  // A stage may load when it is empty or everything downstream moves.
  always_comb begin
    w_adv[PIPE-1] = !r_vld[PIPE-1] || bus.out_ready;
    for (int k = PIPE - 2; k >= 0; k--) begin
      w_adv[k] = !r_vld[k] || w_adv[k+1];
    end
  end

  // Per-stage sources and the slice result each stage will register.
  always_comb begin
    w_vld_src[0] = bus.in_valid;
    w_a_src[0]   = bus.a;
    w_b_src[0]   = w_b0;
    w_c_src[0]   = w_c0;
    w_s_src[0]   = {WIDTH{1'b0}};
    for (int k = 1; k < PIPE; k++) begin
      w_vld_src[k] = r_vld[k-1];
      w_a_src[k]   = r_a[k-1];
      w_b_src[k]   = r_b[k-1];
      w_c_src[k]   = r_c[k-1];
      w_s_src[k]   = r_sum[k-1];
    end
    for (int k = 0; k < PIPE; k++) begin
      w_res[k]  = slice_add(w_a_src[k][k*SLICE +: SLICE], w_b_src[k][k*SLICE +: SLICE], w_c_src[k]);
      w_s_nx[k] = w_s_src[k];
      w_s_nx[k][k*SLICE +: SLICE] = w_res[k][SLICE-1:0];
    end
  end

  // Stage registers; a stage holds its beat while it cannot advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= {WIDTH{1'b0}};
        r_b[k]   <= {WIDTH{1'b0}};
        r_sum[k] <= {WIDTH{1'b0}};
        r_c[k]   <= 1'b0;
        r_ovf[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < PIPE; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= w_vld_src[k];
          r_a[k]   <= w_a_src[k];
          r_b[k]   <= w_b_src[k];
          r_sum[k] <= w_s_nx[k];
          r_c[k]   <= w_res[k][SLICE+1];
          r_ovf[k] <= w_res[k][SLICE+1] ^ w_res[k][SLICE];
        end
      end
    end
  end

  assign bus.in_ready  = !rst && w_adv[0];
  assign bus.out_valid = r_vld[PIPE-1];
  assign bus.sum       = r_sum[PIPE-1];
  assign bus.cout      = r_c[PIPE-1];
  assign bus.ovf       = r_ovf[PIPE-1];
endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Directed and randomised checks of carry_skip_adder_pipe against a queue of expected beats.
module tb_carry_skip_adder_pipe;
  localparam int W   = 32;
  localparam int BLK = 4;
  localparam int P   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  carry_skip_adder_pipe_if #(.WIDTH(W)) bus ();
  carry_skip_adder_pipe #(.WIDTH(W), .BLOCK(BLK), .PIPE(P)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct {
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
    int           t;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc      = 0;
  int           n_out    = 0;
  bit           lat_chk  = 1'b1;
  bit           head_seen = 1'b0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output side: compare every valid cycle (covers stall stability), pop on transfer.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      chk("out_has_expect", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        if (!head_seen && lat_chk) chk("latency", 64'(cyc - sb[0].t), 64'(P));
        head_seen = 1'b1;
        chk("sum",  bus.sum,  sb[0].es);
        chk("cout", bus.cout, sb[0].ec);
        chk("ovf",  bus.ovf,  sb[0].eo);
        if (bus.out_ready) begin
          last_sum  = bus.sum;
          last_cout = bus.cout;
          last_ovf  = bus.ovf;
          n_out++;
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit c, input bit s, input bit ordy, output bit acc);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         cc;
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = c;
`ifdef ADD_SUB_EN
    bus.sub       = s;
`endif
    bus.out_ready = ordy;
    #2;
    chk("in_ready", bus.in_ready, 64'(ordy || (sb.size() < P)));
    acc = v && bus.in_ready;
    if (acc) begin
      bb = b;
      cc = c;
`ifdef ADD_SUB_EN
      if (s) begin
        bb = ~b;
        cc = 1'b1;
      end
`endif
      full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
      sb.push_back('{es: full[W-1:0], ec: full[W],
                     eo: (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]), t: cyc});
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit c, input bit s);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, a, b, c, s, 1'b1, acc);
      if (acc) break;
    end
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain(input string tag);
    bit acc;
    for (int i = 0; i < 50 && sb.size() > 0; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic expect_last(input string tag, input logic [W-1:0] s, input logic c, input logic o);
    chk({tag, "_sum"},  last_sum,  s);
    chk({tag, "_cout"}, last_cout, c);
    chk({tag, "_ovf"},  last_ovf,  o);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int idx;
    int n0;
    bit saw_block;
    bus.in_valid  = 1'b1;
    bus.a         = 32'hDEADBEEF;
    bus.b         = 32'h12345678;
    bus.cin       = 1'b1;
`ifdef ADD_SUB_EN
    bus.sub       = 1'b0;
`endif
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 64'd0);
    chk("rst_sum",       bus.sum,       64'd0);
    chk("rst_cout",      bus.cout,      64'd0);
    chk("rst_ovf",       bus.ovf,       64'd0);
    chk("rst_in_ready",  bus.in_ready,  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 64'd1);

    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    drain("t2a");
    expect_last("t2a", 32'h00000000, 1'b1, 1'b0);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    drain("t2b");
    expect_last("t2b", 32'h80000000, 1'b0, 1'b1);

    send(32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0);
    drain("t3a");
    expect_last("t3a", 32'h00000000, 1'b1, 1'b0);
    send(32'hFFFF0000, 32'h0000FFFF, 1'b0, 1'b0);
    drain("t3b");
    expect_last("t3b", 32'hFFFFFFFF, 1'b0, 1'b0);

    lat_chk   = 1'b0;
    n0        = n_out;
    idx       = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 40 && (idx < 6 || sb.size() > 0); c++) begin
      drive(idx < 6, W'(idx), W'(idx), 1'b0, 1'b0, !(c >= 3 && c <= 5), acc);
      if (idx < 6 && !bus.in_ready) saw_block = 1'b1;
      if (acc) idx++;
    end
    chk("t4_beats_out", 64'(n_out - n0), 64'd6);
    chk("t4_in_ready_blocked", 64'(saw_block), 64'd1);
    chk("t4_last_sum", last_sum, 32'd10);
    drain("t4");
    lat_chk = 1'b1;

    n0 = n_out;
    send(32'd1, 32'd1, 1'b0, 1'b0);
    send(32'd2, 32'd2, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("t5_out_valid_in_rst", bus.out_valid, 64'd0);
    chk("t5_in_ready_in_rst",  bus.in_ready,  64'd0);
    sb.delete();
    head_seen = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'd3, 32'd4, 1'b0, 1'b0);
    drain("t5");
    expect_last("t5", 32'd7, 1'b0, 1'b0);
    chk("t5_beats_out", 64'(n_out - n0), 64'd1);

`ifdef ADD_SUB_EN
    send(32'd5, 32'd7, 1'b0, 1'b1);
    drain("t6a");
    expect_last("t6a", 32'hFFFFFFFE, 1'b0, 1'b0);
    send(32'h80000000, 32'd1, 1'b1, 1'b1);
    drain("t6b");
    expect_last("t6b", 32'h7FFFFFFF, 1'b1, 1'b1);
    send(32'd2, 32'd3, 1'b1, 1'b0);
    drain("t6c");
    expect_last("t6c", 32'd6, 1'b0, 1'b0);
`endif

    lat_chk = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), acc);
    end
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
